pwm_bank: RTL and testbench

- Parametrised successor to the fixed 16-output, single-duty PWM peripheral.
- NUM_CH channels, each with its own duty cycle, and configurable counter resolution (CNT_W).
- Programmable clock prescaler, PWM-path output inversion, and a glitch-free duty update mode (shadowed duty, committed at period boundary).
- Sits behind the SPI peripheral, which drives its byte-wide write port; outputs drive uo_out/uio_out.

---
 rtl/pwm_bank_pkg.sv | 26 ++
 rtl/pwm_timebase.sv | 34 +++
 rtl/pwm_bank.sv | 114 +++++++++++
 tb/tb_pwm_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// Shared register map, control-bit layout and channel limits for the PWM bank.
package pwm_bank_pkg;

  localparam int MAX_CH = 16;

  localparam logic [4:0] ADDR_EN_OUT_LO = 5'h00;
  localparam logic [4:0] ADDR_EN_OUT_HI = 5'h01;
  localparam logic [4:0] ADDR_EN_PWM_LO = 5'h02;
  localparam logic [4:0] ADDR_EN_PWM_HI = 5'h03;
  localparam logic [4:0] ADDR_PRESC     = 5'h04;
  localparam logic [4:0] ADDR_CTRL      = 5'h05;
  localparam logic [4:0] ADDR_DUTY_BASE = 5'h10;

  localparam int CTRL_SYNC_UPD = 0;
  localparam int CTRL_INVERT   = 1;

  typedef struct packed {
    logic invert;
    logic sync_upd;
  } ctrl_t;

  function automatic logic [4:0] duty_addr(input int ch);
    return 5'(int'(ADDR_DUTY_BASE) + ch);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus period counter; cnt runs 0..MAX-1 and advances once per tick.
module pwm_timebase #(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] presc,
  output logic [CNT_W-1:0]   cnt,
  output logic               tick,
  output logic               boundary
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** CNT_W) - 2);

  logic [PRESC_W-1:0] presc_cnt;

  // >= rather than == so a smaller presc written mid-count never stalls the timebase
  assign tick     = (presc_cnt >= presc);
  assign boundary = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// NUM_CH-channel PWM bank: byte-wide register file, shadow/active duty per channel,
// shared timebase and a registered output stage.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** CNT_W) - 2);

  logic [PRESC_W-1:0] presc;
  ctrl_t              ctrl;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic               boundary;
  logic               zero_seen;

  pwm_timebase #(
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .presc   (presc),
    .cnt     (cnt),
    .tick    (tick),
    .boundary(boundary)
  );

  // zero_seen marks that the current cnt==0 stretch has already been announced,
  // so period_start fires once even when the prescaler holds cnt at 0 for many cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      ctrl         <= '0;
      zero_seen    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == ADDR_PRESC)) begin
        presc <= PRESC_W'(wr_data);
      end
      if (wr_en && (wr_addr == ADDR_CTRL)) begin
        ctrl.sync_upd <= wr_data[CTRL_SYNC_UPD];
        ctrl.invert   <= wr_data[CTRL_INVERT];
      end
      if (tick && (cnt == CNT_LAST)) begin
        zero_seen <= 1'b0;
      end else if (cnt == '0) begin
        zero_seen <= 1'b1;
      end
      period_start <= (cnt == '0) && !zero_seen;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [4:0] A_EN_OUT = (i < 8) ? ADDR_EN_OUT_LO : ADDR_EN_OUT_HI;
    localparam logic [4:0] A_EN_PWM = (i < 8) ? ADDR_EN_PWM_LO : ADDR_EN_PWM_HI;
    localparam logic [4:0] A_DUTY   = duty_addr(i);
    localparam int         BIT      = i % 8;

    logic             en_out_q;
    logic             en_pwm_q;
    logic [CNT_W-1:0] duty_shadow;
    logic [CNT_W-1:0] duty_act;
    logic             pwm;
    logic             out_q;

    assign pwm = (cnt < duty_act) ^ ctrl.invert;

    always_ff @(posedge clk) begin
      if (rst) begin
        en_out_q    <= 1'b0;
        en_pwm_q    <= 1'b0;
        duty_shadow <= '0;
        duty_act    <= '0;
        out_q       <= 1'b0;
      end else begin
        if (wr_en && (wr_addr == A_EN_OUT)) begin
          en_out_q <= wr_data[BIT];
        end
        if (wr_en && (wr_addr == A_EN_PWM)) begin
          en_pwm_q <= wr_data[BIT];
        end
        if (wr_en && (wr_addr == A_DUTY)) begin
          duty_shadow <= wr_data[CNT_W-1:0];
        end
        // In sync mode a write landing on the boundary edge misses this commit.
        if (!ctrl.sync_upd || boundary) begin
          duty_act <= duty_shadow;
        end
        if (!en_out_q) begin
          out_q <= 1'b0;
        end else if (!en_pwm_q) begin
          out_q <= 1'b1;
        end else begin
          out_q <= pwm;
        end
      end
    end

    assign out[i] = out_q;
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: a 16-channel instance plus an 8-channel one sharing the write bus.
module tb_pwm_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] out;
  logic        period_start;
  logic [7:0]  out8;
  logic        ps8;

  int total = 0;
  int bad   = 0;
  int hi_cnt[16];
  int ps_cnt;

  always #5 clk = ~clk;

  pwm_bank #(.NUM_CH(16), .CNT_W(8), .PRESC_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .out         (out),
    .period_start(period_start)
  );

  pwm_bank #(.NUM_CH(8), .CNT_W(8), .PRESC_W(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .out         (out8),
    .period_start(ps8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Samples n consecutive cycles; optionally issues one write from sample index wr_at.
  task automatic meas(input int n, input int wr_at, input logic [4:0] a, input logic [7:0] d);
    for (int c = 0; c < 16; c++) hi_cnt[c] = 0;
    ps_cnt = 0;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 16; c++) hi_cnt[c] += int'(out[c]);
      ps_cnt += int'(period_start);
      if (k == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
      end
      step();
      wr_en = 1'b0;
    end
  endtask

  task automatic wait_ps(input string tag);
    int n = 0;
    while (!period_start && n < 2000) begin
      step();
      n++;
    end
    check(tag, period_start, 1);
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // reset dominates writes
    for (int k = 0; k < 3; k++) begin
      wr_en   = 1'b1;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 8'($urandom);
      step();
    end
    check("rst_out", out, 0);
    check("rst_ps", period_start, 0);
    check("rst_out8", out8, 0);
    wr_en = 1'b0;
    rst   = 1'b0;
    step();
    check("ps_after_rst", period_start, 1);
    check("out_after_rst", out, 0);

    // duty/invert cleared: pwm enabled on ch0 stays low
    wr(5'h00, 8'h01);
    wr(5'h02, 8'h01);
    step();
    meas(255, -1, 5'h00, 8'h00);
    check("rst_duty0", hi_cnt[0], 0);
    check("rst_period_ps", ps_cnt, 1);

    // static outputs
    wr(5'h02, 8'h00);
    wr(5'h00, 8'hA5);
    wr(5'h01, 8'h3C);
    step();
    check("static", out, 16'h3CA5);
    check("static8", out8, 8'hA5);
    wr(5'h01, 8'h00);
    step();
    check("static_hi_clr", out, 16'h00A5);
    wr(5'h1F, 8'h55);
    step();
    step();
    check("drop_1f_8ch", out8, 8'hA5);

    // duty and period
    wr(5'h00, 8'h01);
    wr(5'h02, 8'h01);
    wr(5'h10, 8'h40);
    wr(5'h04, 8'h00);
    step();
    meas(255, -1, 5'h00, 8'h00);
    check("duty40", hi_cnt[0], 64);
    check("duty40_ps", ps_cnt, 1);
    check("duty40_off", hi_cnt[1], 0);
    wr(5'h04, 8'h03);
    for (int k = 0; k < 1100; k++) step();
    meas(1020, -1, 5'h00, 8'h00);
    check("presc3", hi_cnt[0], 256);
    check("presc3_ps", ps_cnt, 1);
    wr(5'h04, 8'h00);
    wr(5'h10, 8'hFF);
    step();
    step();
    meas(255, -1, 5'h00, 8'h00);
    check("duty_max", hi_cnt[0], 255);
    wr(5'h10, 8'h00);
    step();
    step();
    meas(255, -1, 5'h00, 8'h00);
    check("duty_zero", hi_cnt[0], 0);

    // sync update
    wr(5'h10, 8'h80);
    wr(5'h05, 8'h01);
    step();
    step();
    wait_ps("sync_align");
    meas(255, 50, 5'h10, 8'h20);
    check("sync_cur", hi_cnt[0], 128);
    check("sync_cur_ps", ps_cnt, 1);
    meas(255, -1, 5'h00, 8'h00);
    check("sync_next", hi_cnt[0], 32);
    meas(255, 253, 5'h10, 8'h60);
    check("bnd_cur", hi_cnt[0], 32);
    meas(255, -1, 5'h00, 8'h00);
    check("bnd_hold", hi_cnt[0], 32);
    meas(255, -1, 5'h00, 8'h00);
    check("bnd_take", hi_cnt[0], 96);
    wr(5'h10, 8'h30);
    wr(5'h05, 8'h00);
    step();
    step();
    meas(255, -1, 5'h00, 8'h00);
    check("sync_off_commit", hi_cnt[0], 48);

    // invert and mixed channels
    wr(5'h05, 8'h02);
    wr(5'h00, 8'h1F);
    wr(5'h02, 8'h0F);
    for (int c = 0; c < 4; c++) wr(5'(5'h10 + c), 8'h10);
    step();
    step();
    meas(255, -1, 5'h00, 8'h00);
    for (int c = 0; c < 4; c++) check($sformatf("inv_ch%0d", c), hi_cnt[c], 239);
    check("inv_static4", hi_cnt[4], 255);
    check("inv_off5", hi_cnt[5], 0);

    // reset mid-period at cnt=100
    wait_ps("mid_align");
    for (int k = 0; k < 99; k++) step();
    check("pre_rst_ch4", out[4], 1);
    rst = 1'b1;
    step();
    check("mid_rst_out", out, 0);
    check("mid_rst_ps", period_start, 0);
    rst = 1'b0;
    step();
    check("ps_restart", period_start, 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 600);
    check("restart_period", n, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
